ir_queue: RTL
=============

Name: ir_queue

Overview:
- Parametrised successor to the single-entry instruction register in the multi-cycle datapath.
- Buffers up to DEPTH fetched instruction words in a circular FIFO, fed by memory-read data.
- Presents the oldest word (head) to the control unit and register file, already split into MIPS fields.
- Adds a consume handshake, flush, occupancy count and an overflow flag; DEPTH=1 gives a one-entry register with explicit hold and release.

Parameters:
- DATA_W, 32, instruction word width; field split assumes 32.
- DEPTH, 4, number of entries; must be a power of two and at least 1.
- PTR_W, $clog2(DEPTH) (minimum 1), read/write pointer width; derived, do not override.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- flush  in  1  discard all entries (branch or jump redirect).
- IRWr  in  1  write strobe; capture R_data this cycle.
- R_data  in  DATA_W  instruction word from memory.
- rd_en  in  1  consume the head entry this cycle.
- valid  out  1  queue non-empty; head fields meaningful.
- full  out  1  count == DEPTH.
- count  out  PTR_W+1  occupancy, 0..DEPTH.
- ovf  out  1  sticky: a write was dropped.
- ins31_0  out  32  head word.
- ins31_26  out  6  opcode.
- ins25_21  out  5  rs.
- ins20_16  out  5  rt.
- ins15_11  out  5  rd.
- ins15_0  out  16  immediate.
- ins5_0  out  6  funct.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - Write and read pointers set to 0, count 0, ovf 0, all storage entries cleared to 0.
  - Reset takes priority over every other input. Reset mid-stream discards all contents.
- Write accepted (wr_ok):
  - IRWr=1 and (full=0, or rd_en=1 with valid=1).
  - The word is stored at the write pointer, which then increments modulo DEPTH (natural wrap).
- Write refused:
  - IRWr=1 while full=1 and rd_en=0.
  - The word is dropped and ovf is set. ovf stays set until reset or flush.
- Read accepted (rd_ok):
  - rd_en=1 and valid=1. The read pointer increments modulo DEPTH.
  - rd_en while empty is ignored: no pointer change, no flag.
- Count update:
  - count_next = count + wr_ok - rd_ok.
  - Simultaneous wr_ok and rd_ok leaves count unchanged; this holds at both empty and full.
  - Full with rd_en and IRWr accepts the new word; full stays 1.
  - Empty with IRWr and rd_en: the read is ignored, the write is accepted, count becomes 1.
- Latency:
  - A word written at edge N appears on the head outputs after edge N if the queue was empty. There is no same-cycle bypass.
  - Head outputs are stable while rd_en=0. This replaces the old "hold while IRWr low" semantics.
- Head outputs:
  - Combinational decode of the storage entry at the read pointer.
  - When valid=0, all ins* outputs are 0.
- Flush (rst_n=1, flush=1):
  - Both pointers set to 0, count 0, ovf 0. Storage contents are not cleared.
  - flush overrides IRWr and rd_en in the same cycle; a concurrent write is discarded.
- Status outputs:
  - valid = (count != 0); full = (count == DEPTH).
  - Both are derived from the registered count, with no extra latency.
- Field split, taken from the head word:
  - [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [15:0] immediate, [5:0] funct, [31:0] whole word.

Decomposition:
- Shared package ir_pkg:
  - Field MSB/LSB constants: OP_HI/OP_LO, RS_HI/RS_LO, RT_HI/RT_LO, RD_HI/RD_LO, IMM_HI/IMM_LO, FN_HI/FN_LO.
  - INSTR_W=32.
  - Reused later by the decoder and control FSM.
- One sub-module, ir_field_split:
  - Purely combinational. Takes a 32-bit word plus a valid bit and drives the six field outputs and the gated word.
- ir_queue holds the pointers, count, ovf and the storage array, and instantiates ir_field_split once on the head entry.

Test Plan:
1. Reset, then single write: rst_n low for 2 cycles -> count=0, valid=0, ins31_0=0. Then IRWr with R_data=0x8C430004 -> next cycle valid=1, ins31_26=0x23, ins25_21=2, ins20_16=3, ins15_0=0x0004.
2. Fill and overflow, DEPTH=4: write 0x00000001..0x00000004 -> full=1, count=4. Write 0x00000005 with rd_en=0 -> dropped, ovf=1. Then pop four times -> head shows 1, 2, 3, 4 in order; valid=0 after the fourth pop.
3. Full with simultaneous read and write: full queue holding 1..4, IRWr=1 with 0xA, rd_en=1 -> count stays 4, head becomes 2. Pop order afterwards is 2, 3, 4, 0xA, confirming pointer wrap.
4. Empty edge cases: empty queue, rd_en=1 and IRWr=1 with 0x012A4020 -> count=1, ins15_11=8, ins5_0=0x20. rd_en=1 alone on an empty queue -> no change, ovf=0.
5. Flush priority: count=3, ovf=1, then flush=1 together with IRWr and rd_en -> count=0, ovf=0, valid=0, ins* all 0. The next write's word appears at the head.
6. Reset mid-operation with DEPTH=1: write 0x1234 and hold with rd_en=0 for 5 cycles -> ins15_0=0x1234 throughout. Assert rst_n=0 together with IRWr -> count=0 and the concurrent write is not stored.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared instruction-word layout for the fetch queue, decoder and control FSM.
// Field bounds follow the MIPS R/I/J encodings.
package ir_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam int unsigned OP_HI  = 31;
  localparam int unsigned OP_LO  = 26;
  localparam int unsigned RS_HI  = 25;
  localparam int unsigned RS_LO  = 21;
  localparam int unsigned RT_HI  = 20;
  localparam int unsigned RT_LO  = 16;
  localparam int unsigned RD_HI  = 15;
  localparam int unsigned RD_LO  = 11;
  localparam int unsigned IMM_HI = 15;
  localparam int unsigned IMM_LO = 0;
  localparam int unsigned FN_HI  = 5;
  localparam int unsigned FN_LO  = 0;

endpackage

// File: rtl/ir_field_split.sv
// Combinational split of an instruction word into its MIPS fields.
// All outputs are forced to zero when the word is not valid.
module ir_field_split
  import ir_pkg::*;
(
  input  logic [INSTR_W-1:0] word,
  input  logic               vld,
  output logic [31:0]        ins31_0,
  output logic [5:0]         ins31_26,
  output logic [4:0]         ins25_21,
  output logic [4:0]         ins20_16,
  output logic [4:0]         ins15_11,
  output logic [15:0]        ins15_0,
  output logic [5:0]         ins5_0
);

  logic [INSTR_W-1:0] gated;

  assign gated    = vld ? word : '0;

  assign ins31_0  = gated;
  assign ins31_26 = gated[OP_HI:OP_LO];
  assign ins25_21 = gated[RS_HI:RS_LO];
  assign ins20_16 = gated[RT_HI:RT_LO];
  assign ins15_11 = gated[RD_HI:RD_LO];
  assign ins15_0  = gated[IMM_HI:IMM_LO];
  assign ins5_0   = gated[FN_HI:FN_LO];

endmodule

// File: rtl/ir_queue.sv
// Circular instruction queue replacing the single-entry instruction register.
// The head entry is decoded into MIPS fields for the control unit and register file.
module ir_queue
  import ir_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              IRWr,
  input  logic [DATA_W-1:0] R_data,
  input  logic              rd_en,
  output logic              valid,
  output logic              full,
  output logic [PTR_W:0]    count,
  output logic              ovf,
  output logic [31:0]       ins31_0,
  output logic [5:0]        ins31_26,
  output logic [4:0]        ins25_21,
  output logic [4:0]        ins20_16,
  output logic [4:0]        ins15_11,
  output logic [15:0]       ins15_0,
  output logic [5:0]        ins5_0
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              mem_we;
  logic              rd_ok, wr_ok;

  // Explicit wrap so DEPTH=1 keeps the pointer pinned at 0.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign valid = (count_q != '0);
  assign full  = (count_q == FULL_CNT);
  assign count = count_q;
  assign ovf   = ovf_q;

  // A full queue still accepts a write when the head is popped in the same cycle.
  assign rd_ok = rd_en & valid;
  assign wr_ok = IRWr & (~full | rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    mem_we   = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (wr_ok) begin
        mem_we   = 1'b1;
        wr_ptr_d = next_ptr(wr_ptr_q);
      end
      if (rd_ok) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end
      if (IRWr && !wr_ok) begin
        ovf_d = 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      if (mem_we) begin
        mem_q[wr_ptr_q] <= R_data;
      end
    end
  end

  ir_field_split u_field_split (
    .word     (mem_q[rd_ptr_q][INSTR_W-1:0]),
    .vld      (valid),
    .ins31_0  (ins31_0),
    .ins31_26 (ins31_26),
    .ins25_21 (ins25_21),
    .ins20_16 (ins20_16),
    .ins15_11 (ins15_11),
    .ins15_0  (ins15_0),
    .ins5_0   (ins5_0)
  );

endmodule
